// File: rtl/automata_pkg.sv
// Shared types and constants for the runtime-programmable automaton engine.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package automata_pkg;

  localparam int MATCH_BITS = 256;
  localparam int CFG_WORDS  = 8;

  typedef enum logic [1:0] {
    CFG_MATCH = 2'd0,
    CFG_ADJ   = 2'd1,
    CFG_ATTR  = 2'd2,
    CFG_RSVD  = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    START_NONE = 2'd0,
    START_SOD  = 2'd1,
    START_ALL  = 2'd2
  } start_type_e;

  // Per-STE attributes; start code 3 is kept as written and behaves like START_NONE.
  typedef struct packed {
    logic       rpt;
    logic [1:0] start;
  } ste_attr_t;

endpackage

// File: rtl/automata_report_fifo.sv
// Synchronous report FIFO with drop-on-full and a sticky overflow flag.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: never stalls the writer; a push while full (without a pop) is dropped and sets ovf.
module automata_report_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/automata_engine_prog.sv
// Programmable homogeneous automaton engine: N_STE STEs step on each accepted 8-bit symbol.
// Latency: 1 cycle from an accepted beat to active_state/report; config error pulses 1 cycle after the write.
// Backpressure: sym_ready follows run; optional report FIFO (AUTOMATA_REPORT_FIFO_EN) drops on full and sets rpt_ovf.
module automata_engine_prog
  import automata_pkg::*;
#(
  parameter int N_STE     = 16,
  parameter int SYM_W     = 8,
  parameter int CNT_W     = 32,
  parameter int RPT_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [4:0]       cfg_ste,
  input  logic [2:0]       cfg_word,
  input  logic [31:0]      cfg_wdata,
  output logic             cfg_err,
  input  logic             run,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] symbol,
  output logic             sym_ready,
  output logic [N_STE-1:0] active_state,
  output logic [N_STE-1:0] report,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [N_STE-1:0] rpt_vec,
  output logic [CNT_W-1:0] rpt_idx,
  output logic             rpt_ovf
);

  logic [MATCH_BITS-1:0] match_tbl [N_STE];
  logic [N_STE-1:0]      pred_tbl  [N_STE];
  ste_attr_t             attr_tbl  [N_STE];

  logic             first_flag;
  logic             beat;
  logic             cfg_bad;
  logic             cfg_ok;
  logic [N_STE-1:0] nxt_en;
  logic [N_STE-1:0] nxt_active;
  logic [N_STE-1:0] rpt_mask;
  logic [N_STE-1:0] nxt_report;

  assign sym_ready = run && !reset;
  assign beat      = sym_valid && sym_ready;

  // Tables may only change while the engine is stopped, so a running automaton is never torn.
  assign cfg_bad = cfg_we && (run || (int'(cfg_ste) >= N_STE) || (cfg_sel == CFG_RSVD));
  assign cfg_ok  = cfg_we && !cfg_bad;

  // Rejected writes are flagged one cycle later.
  always_ff @(posedge clk) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_bad;
  end

  // Config tables: match words, predecessor rows and start/report attributes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_STE; i++) begin
        match_tbl[i] <= '0;
        pred_tbl[i]  <= '0;
        attr_tbl[i]  <= '0;
      end
    end else if (cfg_ok) begin
      for (int i = 0; i < N_STE; i++) begin
        if (cfg_ste == 5'(i)) begin
          case (cfg_sel)
            CFG_MATCH: match_tbl[i][{cfg_word, 5'd0} +: 32] <= cfg_wdata;
            CFG_ADJ:   pred_tbl[i] <= cfg_wdata[N_STE-1:0];
            CFG_ATTR: begin
              attr_tbl[i].start <= cfg_wdata[1:0];
              attr_tbl[i].rpt   <= cfg_wdata[8];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Per-STE enable from predecessors and start type, gated by the symbol match bit.
  always_comb begin
    nxt_en     = '0;
    nxt_active = '0;
    rpt_mask   = '0;
    for (int i = 0; i < N_STE; i++) begin
      nxt_en[i] = (|(pred_tbl[i] & active_state))
               || ((attr_tbl[i].start == START_SOD) && first_flag)
               || (attr_tbl[i].start == START_ALL);
      nxt_active[i] = nxt_en[i] && match_tbl[i][symbol];
      rpt_mask[i]   = attr_tbl[i].rpt;
    end
  end

  assign nxt_report = nxt_active & rpt_mask;

  // Automaton state advances only on accepted beats; bubbles and run=0 hold everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_state <= '0;
      report       <= '0;
      first_flag   <= 1'b1;
    end else if (beat) begin
      active_state <= nxt_active;
      report       <= nxt_report;
      first_flag   <= 1'b0;
    end
  end

`ifdef AUTOMATA_REPORT_FIFO_EN
  logic [CNT_W-1:0]       sym_cnt;
  logic [N_STE+CNT_W-1:0] fifo_head;
  logic                   fifo_empty;
  logic                   unused_fifo_full;

  // Symbol index counter; reports carry the index of the symbol that produced them.
  always_ff @(posedge clk) begin
    if (reset)     sym_cnt <= '0;
    else if (beat) sym_cnt <= sym_cnt + CNT_W'(1);
  end

  automata_report_fifo #(
    .WIDTH (N_STE + CNT_W),
    .DEPTH (RPT_DEPTH)
  ) u_rpt_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (beat && (|nxt_report)),
    .push_dat ({nxt_report, sym_cnt}),
    .pop      (rpt_ready),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .full     (unused_fifo_full),
    .ovf      (rpt_ovf)
  );

  assign rpt_valid          = !fifo_empty;
  assign {rpt_vec, rpt_idx} = fifo_head;
`else
  logic unused_rpt;

  assign unused_rpt = ^{rpt_ready, RPT_DEPTH[0]};
  assign rpt_valid  = 1'b0;
  assign rpt_vec    = '0;
  assign rpt_idx    = '0;
  assign rpt_ovf    = 1'b0;
`endif

endmodule
